// File: rtl/hazard_scoreboard.sv
// Decode-stage RAW hazard scoreboard for the EX/MEM/WB pipeline.
// It also squashes wrong-path work on a flush and drains the pipeline after HALT.
module hazard_scoreboard (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    input  logic [2:0] id_rs_sel,
    input  logic       id_rs_used,
    input  logic [2:0] id_rt_sel,
    input  logic       id_rt_used,
    input  logic [2:0] id_wr_sel,
    input  logic       id_wr_en,
    input  logic       id_halt,
    input  logic       flush,
    output logic       stall,
    output logic       drain_hold,
    output logic       halted,
    output logic       err
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t     state_r;
    state_t     state_nxt_s;
    logic       ex_wr_r;
    logic [2:0] ex_sel_r;
    logic       mem_wr_r;
    logic [2:0] mem_sel_r;
    logic       wb_wr_r;
    logic [2:0] wb_sel_r;
    logic [1:0] drain_cnt_r;
    logic [1:0] stall_cnt_r;
    logic       drain_hold_r;
    logic       halted_r;
    logic       err_r;
    logic       hazard_s;
    logic       insert_s;
    logic       new_wr_s;
    logic [2:0] new_sel_s;
    logic       pipe_empty_s;

    // A busy entry hits when its destination matches a source decode actually reads.
    function automatic logic entry_hit(input logic       wr,
                                       input logic [2:0] sel,
                                       input logic [2:0] rs_sel,
                                       input logic       rs_used,
                                       input logic [2:0] rt_sel,
                                       input logic       rt_used);
        entry_hit = wr & ((rs_used & (sel == rs_sel)) | (rt_used & (sel == rt_sel)));
    endfunction

    // Hazard detection against EX and MEM; WB is covered by the register-file bypass.
    always_comb begin
        hazard_s = entry_hit(ex_wr_r, ex_sel_r, id_rs_sel, id_rs_used, id_rt_sel, id_rt_used)
                 | entry_hit(mem_wr_r, mem_sel_r, id_rs_sel, id_rs_used, id_rt_sel, id_rt_used);
        stall    = (state_r == RUN) & id_valid & hazard_s;
        insert_s = (state_r == RUN) & id_valid & ~stall & ~flush;
        pipe_empty_s = ~ex_wr_r & ~mem_wr_r & ~wb_wr_r;
    end

    // New EX entry and next state of the halt sequencer.
    always_comb begin
        new_wr_s    = 1'b0;
        new_sel_s   = 3'd0;
        state_nxt_s = state_r;
        if (insert_s && !id_halt) begin
            new_wr_s  = id_wr_en;
            new_sel_s = id_wr_sel;
        end else begin
            new_wr_s  = 1'b0;
            new_sel_s = 3'd0;
        end
        case (state_r)
            RUN: begin
                if (insert_s && id_halt) begin
                    state_nxt_s = DRAIN;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DRAIN: begin
                // Only the first drain cycle still has HALT in EX, so only it can be squashed.
                if (flush && (drain_cnt_r == 2'd0)) begin
                    state_nxt_s = RUN;
                end else if ((drain_cnt_r >= 2'd2) && pipe_empty_s) begin
                    state_nxt_s = HALTED;
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            HALTED: begin
                state_nxt_s = HALTED;
            end
            default: begin
                state_nxt_s = RUN;
            end
        endcase
    end

    // Pipeline entries, sequencer state and sticky status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_wr_r      <= 1'b0;
            ex_sel_r     <= 3'd0;
            mem_wr_r     <= 1'b0;
            mem_sel_r    <= 3'd0;
            wb_wr_r      <= 1'b0;
            wb_sel_r     <= 3'd0;
            state_r      <= RUN;
            drain_cnt_r  <= 2'd0;
            stall_cnt_r  <= 2'd0;
            drain_hold_r <= 1'b0;
            halted_r     <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            ex_wr_r   <= new_wr_s;
            ex_sel_r  <= new_sel_s;
            mem_wr_r  <= flush ? 1'b0 : ex_wr_r;
            mem_sel_r <= flush ? 3'd0 : ex_sel_r;
            wb_wr_r   <= mem_wr_r;
            wb_sel_r  <= mem_sel_r;
            state_r   <= state_nxt_s;
            if ((state_r == DRAIN) && (state_nxt_s == DRAIN)) begin
                drain_cnt_r <= (drain_cnt_r == 2'd3) ? drain_cnt_r : drain_cnt_r + 2'd1;
            end else begin
                drain_cnt_r <= 2'd0;
            end
            if (stall) begin
                stall_cnt_r <= (stall_cnt_r == 2'd3) ? stall_cnt_r : stall_cnt_r + 2'd1;
            end else begin
                stall_cnt_r <= 2'd0;
            end
            drain_hold_r <= (state_nxt_s != RUN);
            halted_r     <= (state_nxt_s == HALTED);
            // A genuine hazard clears within two bubbles; a third stall cycle means corruption.
            if ((stall && (stall_cnt_r >= 2'd2)) || (flush && (state_r == HALTED))) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
        end
    end

    assign drain_hold = drain_hold_r;
    assign halted     = halted_r;
    assign err        = err_r;

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Decode-stage hazard controller for the pipelined processor. Tracks destination registers of in-flight instructions in EX, MEM and WB, and stalls the instruction in decode on a read-after-write hazard the register-file bypass cannot cover. Squashes wrong-path entries on a branch flush and sequences halt drain. Sits beside decode; its stall output holds the IF/ID register and injects a bubble into ID/EX.

## Interface
- No parameters (3-bit register select, 8 registers, 3 tracked stages fixed).
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  decode holds a real instruction this cycle
- id_rs_sel  in  3  first read register (instruction[10:8])
- id_rs_used  in  1  instruction reads id_rs_sel
- id_rt_sel  in  3  second read register (instruction[7:5])
- id_rt_used  in  1  instruction reads id_rt_sel
- id_wr_sel  in  3  destination register from the write-register mux
- id_wr_en  in  1  instruction writes the register file
- id_halt  in  1  instruction in decode is HALT
- flush  in  1  branch/jump resolved taken in MEM; EX entry is wrong-path
- stall  out  1  hold IF/ID and PC, insert bubble into EX
- drain_hold  out  1  halt accepted, fetch/decode frozen
- halted  out  1  pipeline empty after HALT, sticky until rst
- err  out  1  internal consistency error, sticky until rst

## Operation
- Scoreboard: three entries EX, MEM, WB, each {wr (1), sel (3)}. Entry "busy" = wr=1.
- Hazard match: busy EX or busy MEM entry whose sel equals id_rs_sel (if id_rs_used) or id_rt_sel (if id_rt_used). WB entries never match (bypass covers same-cycle write). Register 0 is a normal register; no special-casing.
- stall = (state==RUN) & id_valid & hazard match. Combinational from inputs and registered entries.
- Each edge (no reset): WB<-MEM, MEM<-EX, EX<-new. new = {id_wr_en, id_wr_sel} when state==RUN & id_valid & !stall & !flush; otherwise bubble {0,000}.
- flush: EX entry squashed (MEM receives bubble instead of EX); decode instruction not inserted. MEM and WB advance normally.
- FSM states RUN, DRAIN, HALTED.
  - RUN -> DRAIN: id_valid & id_halt & !stall & !flush. HALT enters EX as a non-writing entry (id_wr_en ignored for HALT).
  - DRAIN: no insertion; drain_hold=1. Flush on the first DRAIN cycle (HALT still in EX) squashes HALT and returns to RUN. Flush in later DRAIN cycles ignored.
  - DRAIN -> HALTED: when EX, MEM, WB all non-busy and HALT has left WB (two cycles after entering WB's successor, i.e. 3 cycles after DRAIN entry with no flush).
  - HALTED: absorbing; halted=1, drain_hold=1, stall=0; entries stay empty.
- err set when stall has been asserted for 3 consecutive cycles (a hazard can never outlive 2 bubbles), or when flush arrives in HALTED.

## Timing
- Reset: all entries {0,000}, state RUN, stall=0, drain_hold=0, halted=0, err=0 from the cycle after rst sampled high; rst mid-drain or mid-stall returns to these values with no residue.
- Stall latency: 0 cycles (same cycle as decode). Dependent on EX producer: 2 stall cycles; on MEM producer: 1; on WB producer: 0.
- Simultaneous stall and flush: flush wins; no insertion, stall still driven for this cycle but irrelevant since decode is killed.
- HALT to halted: 3 cycles after acceptance edge with no flush.
- drain_hold registered (valid cycle after acceptance edge); halted registered.

## Test plan
- Back-to-back: ADD r3 writes, next instr reads r3 as rs -> stall=1 for exactly 2 cycles, then issues; EX entry {1,011}.
- One-gap: writer of r5, independent instr, reader of r5 as rt -> stall=1 for 1 cycle; reader with rt_used=0 -> no stall.
- WB overlap: reader of r2 three instrs after writer -> stall=0 throughout.
- Flush: writer of r4 in EX, flush=1, next decode reads r4 -> entry squashed, MEM gets bubble, no stall next cycle.
- Halt: HALT accepted with no writers in flight -> drain_hold=1 next cycle, halted=1 three cycles after acceptance; flush on first DRAIN cycle instead -> back to RUN, halted stays 0.
- Reset mid-stall: rst during second stall cycle -> next cycle all outputs 0, entries empty, err=0.
